// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants for the serial PHY: byte width, comma character and default preamble length.
// Imported by the transmit serializer and its receive-side counterpart.
package paralelo_serial_tx_pkg;

    localparam int BYTE_W         = 8;
    localparam int BIT_CNT_W      = 3;
    localparam int BYTE_IDX_W     = 4;
    localparam int N_SYNC_DEFAULT = 4;

    localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: sends an N_SYNC comma preamble after reset, then
// shifts accepted bytes out MSB-first, filling unused slots with commas.
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int                N_SYNC = N_SYNC_DEFAULT,
    parameter logic [BYTE_W-1:0] COMMA  = COMMA_BYTE
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              active_out
);

    localparam logic [BYTE_IDX_W-1:0] SYNC_LAST = BYTE_IDX_W'(N_SYNC - 1);
    localparam logic [BYTE_IDX_W-1:0] SYNC_DONE = BYTE_IDX_W'(N_SYNC);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(BYTE_W - 1);

    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [BYTE_IDX_W-1:0] byte_idx_reg, byte_idx_next;
    logic [BYTE_W-1:0]     shreg_reg, shreg_next;
    logic [BYTE_W-1:0]     hold_reg, hold_next;
    logic                  hold_valid_reg, hold_valid_next;
    logic                  data_out_reg, data_out_next;
    logic                  active_reg, active_next;

    logic              slot_start;
    logic              slot_end;
    logic              accept;
    logic [BYTE_W-1:0] load_byte;

    // Handshake opens only on the last bit of a slot, so an accepted byte
    // is always consumed by the very next slot start.
    always_comb begin
        slot_start = (bit_cnt_reg == '0);
        slot_end   = (bit_cnt_reg == BIT_LAST);
        ready_out  = slot_end && (byte_idx_reg >= SYNC_LAST);
        accept     = valid_in && ready_out;
        load_byte  = hold_valid_reg ? hold_reg : COMMA;
    end

    always_comb begin
        bit_cnt_next    = bit_cnt_reg + 1'b1;
        byte_idx_next   = byte_idx_reg;
        shreg_next      = shreg_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        data_out_next   = shreg_reg[BIT_LAST - bit_cnt_reg];
        active_next     = active_reg;

        if (slot_end && (byte_idx_reg != SYNC_DONE)) begin
            byte_idx_next = byte_idx_reg + 1'b1;
        end

        if (slot_start) begin
            shreg_next      = load_byte;
            data_out_next   = load_byte[BYTE_W-1];
            hold_valid_next = 1'b0;
            if (byte_idx_reg == SYNC_DONE) begin
                active_next = 1'b1;
            end
        end

        if (accept) begin
            hold_next       = data_in;
            hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            bit_cnt_reg    <= '0;
            byte_idx_reg   <= '0;
            shreg_reg      <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            data_out_reg   <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            bit_cnt_reg    <= bit_cnt_next;
            byte_idx_reg   <= byte_idx_next;
            shreg_reg      <= shreg_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            data_out_reg   <= data_out_next;
            active_reg     <= active_next;
        end
    end

    assign data_out   = data_out_reg;
    assign active_out = active_reg;

endmodule
